// File: rtl/cpu_pkg.sv
// Shared fetch/decode types and constants.
//   XLEN     : datapath and address width
//   NOP_WORD : instruction placed in IF/ID on reset, flush or bubble (sll $0,$0,0)
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Clear the byte-offset bits to form a word address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request (stage -> memory)
//   imem_addr  : word address, bits [1:0] zero (stage -> memory)
//   imem_ack   : one-cycle response strobe (memory -> stage)
//   imem_rdata : instruction word, valid with imem_ack (memory -> stage)
interface fetch_decode_stage_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_decode_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, asynchronous active-low reset
//   stall_i    : hold current contents
//   flush_i    : clear to NOP (beats stall_i)
//   load_i     : d_i carries a real instruction; otherwise insert a bubble
//   d_i / q_o  : register input / contents
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall_i,
  input  logic   flush_i,
  input  logic   load_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  localparam if_id_t BUBBLE = '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= BUBBLE;
    end else if (flush_i) begin
      q_o <= BUBBLE;
    end else if (!stall_i) begin
      q_o <= load_i ? d_i : BUBBLE;
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch-to-decode stage: runs the variable-latency instruction-memory
// handshake for pc_f, loads IF/ID, buffers one word while decode stalls and
// drops responses made stale by a flush.
//   clk, rst_n             : clock, asynchronous active-low reset
//   pc_f                   : current fetch PC
//   stall_d, flush_d       : hazard-unit hold / clear of IF/ID
//   imem                   : instruction-memory bus (master side)
//   instr_d, pc_plus4_d,
//   valid_d                : IF/ID contents
//   fetch_stall            : freeze pc_f while no instruction is ready
//   perf_fetched,
//   perf_wait_cycles       : only with FETCH_PERF_EN defined
module fetch_decode_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       pc_f,
  input  logic                  stall_d,
  input  logic                  flush_d,
  fetch_decode_stage_if.master  imem,
  output logic [XLEN-1:0]       instr_d,
  output logic [XLEN-1:0]       pc_plus4_d,
  output logic                  valid_d,
  output logic                  fetch_stall
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_wait_cycles
`endif
);

  fetch_state_e    state_q;
  logic            drop_q;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] hold_instr_q;
  logic [XLEN-1:0] hold_pc4_q;

  logic            req_c;
  logic [XLEN-1:0] cur_pc_c;
  logic [XLEN-1:0] pc4_c;
  logic            ack_c;
  logic            resp_c;
  logic            take_c;
  if_id_t          ifid_d;
  if_id_t          ifid_q;

  // Request is suppressed in HOLD and while reset is asserted.
  assign req_c    = rst_n && (state_q != HOLD);
  assign cur_pc_c = (state_q == WAIT) ? req_pc_q : word_align(pc_f);
  assign pc4_c    = cur_pc_c + XLEN'(4);
  assign ack_c    = req_c && imem.imem_ack;
  // A real word arrived (not the answer to a flushed request).
  assign resp_c   = ack_c && !((state_q == WAIT) && drop_q);
  assign take_c   = resp_c && !flush_d;

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = cur_pc_c;

  // A dropped ack still leaves no instruction, so pc_f stays frozen.
  assign fetch_stall = !resp_c;

  // Fetch FSM, drop flag and hold buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ISSUE;
      drop_q       <= 1'b0;
      req_pc_q     <= '0;
      hold_instr_q <= NOP_WORD;
      hold_pc4_q   <= '0;
    end else begin
      if (take_c && stall_d) begin
        hold_instr_q <= imem.imem_rdata;
        hold_pc4_q   <= pc4_c;
      end
      case (state_q)
        ISSUE: begin
          if (!ack_c) begin
            state_q  <= WAIT;
            req_pc_q <= cur_pc_c;
            drop_q   <= flush_d;
          end else if (take_c && stall_d) begin
            state_q <= HOLD;
          end
        end
        WAIT: begin
          if (ack_c) begin
            drop_q  <= 1'b0;
            state_q <= (take_c && stall_d) ? HOLD : ISSUE;
          end else if (flush_d) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          if (flush_d || !stall_d) state_q <= ISSUE;
        end
        default: state_q <= ISSUE;
      endcase
    end
  end

  // IF/ID source: buffered word in HOLD, otherwise the memory response.
  always_comb begin
    ifid_d = '{instr: imem.imem_rdata, pc_plus4: pc4_c, valid: 1'b1};
    if (state_q == HOLD) begin
      ifid_d = '{instr: hold_instr_q, pc_plus4: hold_pc4_q, valid: 1'b1};
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall_i (stall_d),
    .flush_i (flush_d),
    .load_i  (take_c || (state_q == HOLD)),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign instr_d    = ifid_q.instr;
  assign pc_plus4_d = ifid_q.pc_plus4;
  assign valid_d    = ifid_q.valid;

`ifdef FETCH_PERF_EN
  // Delivered-word and stall-cycle counters, free-running with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched     <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (resp_c)      perf_fetched     <= perf_fetched + 32'd1;
      if (fetch_stall) perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Sits directly downstream of the fetch-stage PC register.
- Takes the fetch PC (`pc_f`), runs the instruction-memory request/acknowledge handshake with variable latency, and loads the returned word into the IF/ID pipeline register for decode.
- Buffers a returned instruction while decode is stalled.
- Discards responses made stale by a flush.
- Raises a stall request to the hazard unit while no instruction is ready.

Parameters:
- XLEN, 32, datapath and address width.
- NOP_WORD, 32'h0000_0000, word loaded into `instr_d` on reset or flush (`sll $0,$0,0`).

Ports:
- clk  in  1  system clock; all state updates on rising edge (`pc_f` changes on falling edge).
- rst_n  in  1  asynchronous, active-low reset.
- pc_f  in  XLEN  current fetch PC.
- stall_d  in  1  hazard unit: hold IF/ID contents.
- flush_d  in  1  hazard unit: clear IF/ID; taken branch/jump redirect.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  word address; bits [1:0] forced to 0.
- imem_ack  in  1  one-cycle response strobe; legal in the same cycle as `imem_req` or any later cycle.
- imem_rdata  in  XLEN  instruction word, valid with `imem_ack`.
- instr_d  out  XLEN  IF/ID instruction.
- pc_plus4_d  out  XLEN  IF/ID PC+4 of `instr_d`.
- valid_d  out  1  IF/ID holds a real instruction.
- fetch_stall  out  1  to hazard unit; must freeze `pc_f` (`stall_f`) while high.

Behaviour:
Reset (rst_n low, asynchronous):
- `instr_d` = NOP_WORD, `pc_plus4_d` = 0, `valid_d` = 0.
- State = ISSUE, drop = 0, hold buffer empty.
- `imem_req` = 0 while `rst_n` is low.

FSM states:
- ISSUE
  - `imem_req` = 1; `imem_addr` = {`pc_f[31:2]`, 2'b00} (combinational from `pc_f`); PC latched into `req_pc`.
  - ack this cycle: response handled as below; remain in ISSUE.
  - no ack: go to WAIT.
- WAIT
  - `imem_req` = 1; `imem_addr` = `req_pc`, held stable until ack.
  - On ack with drop = 1: discard data, clear drop, go to ISSUE.
  - On ack with drop = 0: handle response, go to ISSUE, or to HOLD if buffered.
- HOLD
  - `imem_req` = 0; instruction and `req_pc`+4 sit in the hold buffer.
  - When `stall_d` = 0: load buffer into IF/ID, go to ISSUE.

Response handling (ack, not dropped):
- `stall_d` = 0: IF/ID <= {`imem_rdata`, `req_pc`+4, valid = 1} at this edge.
- `stall_d` = 1: write the hold buffer, go to HOLD.

`fetch_stall` = 1 when:
- in WAIT without ack, or
- in ISSUE without ack, or
- in HOLD.

Otherwise `fetch_stall` = 0, giving 1 instr/cycle with zero-wait memory.

IF/ID with no new instruction and `stall_d` = 0: `valid_d` <= 0, `instr_d` <= NOP_WORD (bubble).

`flush_d`:
- Highest priority; `flush_d` beats `stall_d`.
- IF/ID <= {NOP_WORD, 0, 0}.
- In WAIT without ack: set drop.
- In ISSUE/WAIT with ack the same cycle: discard the word.
- In HOLD: empty the buffer, go to ISSUE.
- The next request uses the redirected `pc_f`.

Other rules:
- PC+4 arithmetic wraps modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-WAIT abandons the request; a late ack after reset, with drop = 0, is ignored because state is ISSUE with `imem_req` = 0 during reset.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output ports `perf_fetched` (32) and `perf_wait_cycles` (32).
  - `perf_fetched` counts non-dropped acks.
  - `perf_wait_cycles` counts cycles with `fetch_stall` = 1.
  - Both wrap, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package cpu_pkg:
  - XLEN
  - NOP_WORD
  - fetch FSM state typedef {ISSUE, WAIT, HOLD}
  - IF/ID struct {instr, pc_plus4, valid}
- Sub-module if_id_reg: IF/ID register with stall, flush and asynchronous active-low reset.
- FSM, drop flag and hold buffer stay in the top.

Test Plan:
- Zero-wait memory (ack same cycle as req), `pc_f` = 0,4,8 -> `instr_d` follows `rdata` each cycle, `pc_plus4_d` = 4,8,12, `valid_d` = 1, `fetch_stall` = 0 throughout.
- Ack 3 cycles after req at `pc_f` = 0x40 -> `imem_addr` = 0x40 stable for 3 cycles, `fetch_stall` = 1 for 3 cycles, then `instr_d` = `rdata`, `pc_plus4_d` = 0x44.
- Ack while `stall_d` = 1 for 2 cycles -> IF/ID unchanged, `imem_req` = 0, `fetch_stall` = 1; buffered word appears at the edge after `stall_d` falls.
- `flush_d` during WAIT (req `pc` 0x80, `pc_f` redirected to 0x200) -> `valid_d` = 0, `instr_d` = 0; ack data for 0x80 discarded; next request `imem_addr` = 0x200.
- `flush_d` and `stall_d` both high with ack -> IF/ID = NOP, `valid_d` = 0, word not buffered.
- `rst_n` low mid-WAIT, then late ack -> all outputs at reset values; first request after release uses current `pc_f`.
